// File: rtl/adc_acq_sequencer_pkg.sv
// Shared definitions for the ADC acquisition sequencer: FSM states,
// adc_manager status field layout and the minimum trigger period.
package adc_acq_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  localparam logic [1:0] ADC_MODE_CONVERSION = 2'b00;
  localparam int         MODE_LSB            = 2;
  localparam int         MIN_DIVIDER         = 2;

  function automatic logic mode_is_conversion(input logic [1:0] mode);
    return mode == ADC_MODE_CONVERSION;
  endfunction

endpackage

// File: rtl/adc_acq_sequencer_cmd_fifo.sv
// Register-command buffer: power-of-two FIFO with registered full/empty flags.
// A push at full is dropped; a simultaneous push and pop leave occupancy unchanged.
module adc_acq_sequencer_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Flags come from the next occupancy so they stay registered yet exact.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Sequences adc_manager: forwards buffered register commands, then issues
// conversion triggers at a programmable period for a count or continuously.
module adc_acq_sequencer
  import adc_acq_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH   = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int CMD_DEPTH   = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DIV_WIDTH-1:0]   cfg_divider,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            s_axis_cmd_tdata,
  input  logic                   s_axis_cmd_tvalid,
  output logic                   s_axis_cmd_tready,
  output logic [31:0]            m_axis_reg_tdata,
  output logic                   m_axis_reg_tvalid,
  input  logic                   m_axis_reg_tready,
  input  logic                   adc_ready,
  input  logic [31:0]            adc_status,
  output logic                   trigger,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [COUNT_WIDTH-1:0] conv_issued
);

  seq_state_t             state;
  seq_state_t             state_next;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   timer_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] issued_inc;
  logic                   ready_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   adc_ok;
  logic                   load_cfg;
  logic                   fire;
  logic                   skip;
  logic                   finish;
  logic                   unused_status;

  assign unused_status = ^{adc_status[31:MODE_LSB+2], adc_status[MODE_LSB-1:0]};

  assign adc_ok     = adc_ready && mode_is_conversion(adc_status[MODE_LSB +: 2]);
  assign issued_inc = conv_issued + 1'b1;
  assign busy       = (state != ST_IDLE);

  // ready_q keeps tready low through reset and for the first released cycle.
  assign s_axis_cmd_tready = ready_q & ~fifo_full;
  assign fifo_push         = s_axis_cmd_tvalid & s_axis_cmd_tready;
  assign m_axis_reg_tvalid = ~fifo_empty & ((state == ST_IDLE) || (state == ST_CFG));
  assign fifo_pop          = m_axis_reg_tvalid & m_axis_reg_tready;

  adc_acq_sequencer_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (32)
  ) u_cmd_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (fifo_push),
    .push_data (s_axis_cmd_tdata),
    .pop       (fifo_pop),
    .pop_data  (m_axis_reg_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    load_cfg   = 1'b0;
    fire       = 1'b0;
    skip       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next = ST_CFG;
          load_cfg   = 1'b1;
        end
      end
      ST_CFG: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (fifo_empty && adc_ok) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop takes priority over a trigger slot falling in the same cycle.
        if (stop) begin
          state_next = ST_DRAIN;
        end else if (timer_q == '0) begin
          if (adc_ok) begin
            fire = 1'b1;
            if ((count_q != '0) && (issued_inc == count_q)) begin
              state_next = ST_DRAIN;
            end
          end else begin
            skip = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (adc_ready) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      div_q       <= DIV_WIDTH'(MIN_DIVIDER);
      count_q     <= '0;
      timer_q     <= '0;
      conv_issued <= '0;
      overrun     <= 1'b0;
      trigger     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= 1'b1;
      trigger <= fire;
      done    <= finish;
      if (load_cfg) begin
        div_q       <= (cfg_divider < DIV_WIDTH'(MIN_DIVIDER)) ? DIV_WIDTH'(MIN_DIVIDER)
                                                                : cfg_divider;
        count_q     <= cfg_count;
        conv_issued <= '0;
        overrun     <= 1'b0;
      end
      if (fire) begin
        conv_issued <= issued_inc;
      end
      if (skip) begin
        overrun <= 1'b1;
      end
      // The timer reloads to div-1 on every slot, so slots repeat every div cycles.
      if (state == ST_CFG) begin
        timer_q <= '0;
      end else if (state == ST_RUN) begin
        timer_q <= (timer_q == '0) ? (div_q - DIV_WIDTH'(1)) : (timer_q - DIV_WIDTH'(1));
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed self-checking bench for adc_acq_sequencer: command forwarding,
// trigger timing, divider clamp, overrun, stop handling and buffer behaviour.
module tb_adc_acq_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cfg_divider = '0;
  logic [31:0] cfg_count = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] s_axis_cmd_tdata = '0;
  logic        s_axis_cmd_tvalid = 1'b0;
  logic        s_axis_cmd_tready;
  logic [31:0] m_axis_reg_tdata;
  logic        m_axis_reg_tvalid;
  logic        m_axis_reg_tready = 1'b0;
  logic        adc_ready = 1'b0;
  logic [31:0] adc_status = '0;
  logic        trigger;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [31:0] conv_issued;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 aclk = ~aclk;

  adc_acq_sequencer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .cfg_divider       (cfg_divider),
    .cfg_count         (cfg_count),
    .start             (start),
    .stop              (stop),
    .s_axis_cmd_tdata  (s_axis_cmd_tdata),
    .s_axis_cmd_tvalid (s_axis_cmd_tvalid),
    .s_axis_cmd_tready (s_axis_cmd_tready),
    .m_axis_reg_tdata  (m_axis_reg_tdata),
    .m_axis_reg_tvalid (m_axis_reg_tvalid),
    .m_axis_reg_tready (m_axis_reg_tready),
    .adc_ready         (adc_ready),
    .adc_status        (adc_status),
    .trigger           (trigger),
    .busy              (busy),
    .done              (done),
    .overrun           (overrun),
    .conv_issued       (conv_issued)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic tick_n(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Returns the number of ticks until trigger is seen high, or -1 on timeout.
  task automatic wait_trigger(input int limit, output int ticks);
    ticks = -1;
    for (int i = 1; i <= limit && ticks < 0; i++) begin
      tick();
      if (trigger === 1'b1) ticks = i;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] div, input logic [31:0] count);
    cfg_divider = div;
    cfg_count   = count;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] data);
    s_axis_cmd_tdata  = data;
    s_axis_cmd_tvalid = 1'b1;
    tick();
    s_axis_cmd_tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset held with start pulsed.
    start = 1'b1;
    tick_n(3);
    check_output("rst_trigger", trigger, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_mvalid", m_axis_reg_tvalid, 0);
    check_output("rst_issued", conv_issued, 0);
    aresetn = 1'b1;
    start   = 1'b0;
    tick();
    check_output("rst_tready", s_axis_cmd_tready, 1);
    check_output("rst_busy_after", busy, 0);

    // Two commands forwarded in order, then div=10 count=3.
    adc_ready  = 1'b1;
    adc_status = 32'h0;
    push_cmd(32'h00A1_0001);
    push_cmd(32'h00B2_0002);
    check_output("head_valid", m_axis_reg_tvalid, 1);
    check_output("head_data", m_axis_reg_tdata, 32'h00A1_0001);
    tick();
    check_output("head_hold", m_axis_reg_tdata, 32'h00A1_0001);
    apply_stimulus(10, 3);
    check_output("cfg_busy", busy, 1);
    m_axis_reg_tready = 1'b1;
    check_output("fwd0_data", m_axis_reg_tdata, 32'h00A1_0001);
    tick();
    check_output("fwd1_valid", m_axis_reg_tvalid, 1);
    check_output("fwd1_data", m_axis_reg_tdata, 32'h00B2_0002);
    tick();
    check_output("fwd_empty", m_axis_reg_tvalid, 0);
    wait_trigger(20, n);
    check_output("t2_first_lat", n, 2);
    check_output("t2_issued1", conv_issued, 1);
    tick();
    check_output("t2_pulse", trigger, 0);
    wait_trigger(30, n);
    check_output("t2_period1", n, 9);
    check_output("t2_issued2", conv_issued, 2);
    wait_trigger(30, n);
    check_output("t2_period2", n, 10);
    check_output("t2_issued3", conv_issued, 3);
    adc_ready = 1'b0;
    tick_n(2);
    check_output("t2_drain_busy", busy, 1);
    check_output("t2_drain_nodone", done, 0);
    adc_ready = 1'b1;
    tick();
    check_output("t2_done", done, 1);
    check_output("t2_idle", busy, 0);
    tick();
    check_output("t2_done_pulse", done, 0);
    check_output("t2_issued_final", conv_issued, 3);

    // Divider of 1 is clamped to 2.
    apply_stimulus(1, 2);
    wait_trigger(10, n);
    check_output("t3_first_lat", n, 2);
    wait_trigger(10, n);
    check_output("t3_period", n, 2);
    tick();
    check_output("t3_done", done, 1);
    check_output("t3_issued", conv_issued, 2);

    // Skipped slot sets overrun; next trigger at +16.
    apply_stimulus(8, 3);
    wait_trigger(10, n);
    check_output("t4_first_lat", n, 2);
    adc_ready = 1'b0;
    tick_n(8);
    check_output("t4_skip_trig", trigger, 0);
    check_output("t4_overrun", overrun, 1);
    adc_ready = 1'b1;
    wait_trigger(20, n);
    check_output("t4_after_skip", n, 8);
    check_output("t4_issued2", conv_issued, 2);
    wait_trigger(20, n);
    check_output("t4_period", n, 8);
    tick();
    check_output("t4_done", done, 1);
    check_output("t4_overrun_sticky", overrun, 1);

    // Continuous run, stop coincident with a trigger slot.
    apply_stimulus(4, 0);
    check_output("t5_overrun_clr", overrun, 0);
    check_output("t5_issued_clr", conv_issued, 0);
    wait_trigger(10, n);
    check_output("t5_first_lat", n, 2);
    tick_n(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_output("t5_stop_notrig", trigger, 0);
    check_output("t5_stop_issued", conv_issued, 1);
    check_output("t5_drain_busy", busy, 1);
    tick();
    check_output("t5_done", done, 1);
    check_output("t5_idle", busy, 0);

    // Non-conversion mode holds CFG; command pushed in RUN stays buffered.
    m_axis_reg_tready = 1'b0;
    adc_status = 32'h0000_000C;
    apply_stimulus(5, 0);
    tick_n(4);
    check_output("t6_cfg_busy", busy, 1);
    check_output("t6_cfg_notrig", trigger, 0);
    adc_status = 32'h0;
    wait_trigger(10, n);
    check_output("t6_run_lat", n, 2);
    push_cmd(32'h00C3_0003);
    check_output("t6_run_hold", m_axis_reg_tvalid, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check_output("t6_done", done, 1);
    check_output("t6_idle_valid", m_axis_reg_tvalid, 1);
    check_output("t6_idle_data", m_axis_reg_tdata, 32'h00C3_0003);

    // Stop in CFG aborts without done; buffer keeps its contents.
    adc_status = 32'h0000_000C;
    apply_stimulus(5, 0);
    check_output("t6b_cfg_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_output("t6b_abort_idle", busy, 0);
    check_output("t6b_abort_nodone", done, 0);
    check_output("t6b_keep_data", m_axis_reg_tdata, 32'h00C3_0003);
    tick();
    check_output("t6b_nodone_late", done, 0);

    // start and stop together: stop wins.
    adc_status = 32'h0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_output("ss_ignored", busy, 0);

    // Fill to full, refused push, drain in order.
    push_cmd(32'h00D4_0004);
    push_cmd(32'h00E5_0005);
    push_cmd(32'h00F6_0006);
    check_output("full_tready", s_axis_cmd_tready, 0);
    push_cmd(32'h0017_0007);
    m_axis_reg_tready = 1'b1;
    check_output("drain0", m_axis_reg_tdata, 32'h00C3_0003);
    tick();
    check_output("drain1", m_axis_reg_tdata, 32'h00D4_0004);
    check_output("drain_tready", s_axis_cmd_tready, 1);
    tick();
    check_output("drain2", m_axis_reg_tdata, 32'h00E5_0005);
    tick();
    check_output("drain3", m_axis_reg_tdata, 32'h00F6_0006);
    tick();
    check_output("drain_empty", m_axis_reg_tvalid, 0);

    // Reset mid-run clears state and buffer.
    apply_stimulus(3, 0);
    wait_trigger(10, n);
    check_output("mr_first_lat", n, 2);
    push_cmd(32'h0028_0008);
    #2;
    aresetn = 1'b0;
    #1;
    check_output("mr_busy", busy, 0);
    check_output("mr_issued", conv_issued, 0);
    check_output("mr_trigger", trigger, 0);
    aresetn = 1'b1;
    tick();
    check_output("mr_buffer_lost", m_axis_reg_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
